// File: rtl/sme_driver.sv
// Transmit-side front end for the string matching engine: buffers one string/pattern
// record, replays it as a framed gap-free burst, and returns the SME result upstream.
module sme_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_trunc,
    output logic       busy
);
    localparam int CNT_W  = $clog2(STR_MAX + 1);
    localparam int ADDR_W = $clog2(STR_MAX);
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] STR_LIM  = CNT_W'(STR_MAX);
    localparam logic [CNT_W-1:0] PAT_LIM  = CNT_W'(PAT_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic               kind_reg, kind_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   idx_reg, idx_next;
    logic               trunc_reg, trunc_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               in_ready_reg, in_ready_next;
    logic [7:0]         chardata_reg;
    logic               isstring_reg, isstring_next;
    logic               ispattern_reg, ispattern_next;
    logic               res_valid_reg, res_valid_next;
    logic               res_match_reg, res_match_next;
    logic [4:0]         res_index_reg, res_index_next;
    logic               res_timeout_reg, res_timeout_next;
    logic               res_trunc_reg, res_trunc_next;
    logic               busy_reg, busy_next;

    logic [7:0]         buf_mem [STR_MAX];
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic               rd_en;
    logic               accept;
    logic [CNT_W-1:0]   lim;

    assign accept = in_valid && in_ready_reg;
    assign lim    = kind_reg ? PAT_LIM : STR_LIM;

    always_comb begin
        state_next       = state_reg;
        kind_next        = kind_reg;
        cnt_next         = cnt_reg;
        idx_next         = idx_reg;
        trunc_next       = trunc_reg;
        timer_next       = timer_reg;
        isstring_next    = isstring_reg;
        ispattern_next   = ispattern_reg;
        res_valid_next   = res_valid_reg;
        res_match_next   = res_match_reg;
        res_index_next   = res_index_reg;
        res_timeout_next = res_timeout_reg;
        res_trunc_next   = res_trunc_reg;
        wr_en            = 1'b0;
        wr_addr          = cnt_reg[ADDR_W-1:0];
        rd_en            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    kind_next  = in_kind;
                    cnt_next   = CNT_W'(1);
                    idx_next   = '0;
                    trunc_next = 1'b0;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    state_next = in_last ? SEND : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    // Bytes past the per-kind limit are swallowed so the record still ends cleanly
                    if (cnt_reg < lim) begin
                        wr_en    = 1'b1;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else begin
                        trunc_next = 1'b1;
                    end
                    if (in_last) begin
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                if (idx_reg < cnt_reg) begin
                    rd_en          = 1'b1;
                    isstring_next  = ~kind_reg;
                    ispattern_next = kind_reg;
                    idx_next       = idx_reg + CNT_W'(1);
                end else begin
                    isstring_next  = 1'b0;
                    ispattern_next = 1'b0;
                    timer_next     = '0;
                    state_next     = kind_reg ? WAIT : IDLE;
                end
            end
            WAIT: begin
                // A real SME answer takes priority over a timeout landing on the same cycle
                if (sme_valid) begin
                    res_match_next   = sme_match;
                    res_index_next   = sme_match_index;
                    res_timeout_next = 1'b0;
                    res_trunc_next   = trunc_reg;
                    res_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (timer_reg == TMR_LAST) begin
                    res_match_next   = 1'b0;
                    res_index_next   = '0;
                    res_timeout_next = 1'b1;
                    res_trunc_next   = trunc_reg;
                    res_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    trunc_next     = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        in_ready_next = (state_next == IDLE) || (state_next == LOAD);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            kind_reg        <= 1'b0;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            trunc_reg       <= 1'b0;
            timer_reg       <= '0;
            in_ready_reg    <= 1'b0;
            chardata_reg    <= '0;
            isstring_reg    <= 1'b0;
            ispattern_reg   <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_match_reg   <= 1'b0;
            res_index_reg   <= '0;
            res_timeout_reg <= 1'b0;
            res_trunc_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            kind_reg        <= kind_next;
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            trunc_reg       <= trunc_next;
            timer_reg       <= timer_next;
            in_ready_reg    <= in_ready_next;
            isstring_reg    <= isstring_next;
            ispattern_reg   <= ispattern_next;
            res_valid_reg   <= res_valid_next;
            res_match_reg   <= res_match_next;
            res_index_reg   <= res_index_next;
            res_timeout_reg <= res_timeout_next;
            res_trunc_reg   <= res_trunc_next;
            busy_reg        <= busy_next;
            if (rd_en) begin
                chardata_reg <= buf_mem[idx_reg[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= in_data;
        end
    end

    assign in_ready      = in_ready_reg;
    assign sme_chardata  = chardata_reg;
    assign sme_isstring  = isstring_reg;
    assign sme_ispattern = ispattern_reg;
    assign res_valid     = res_valid_reg;
    assign res_match     = res_match_reg;
    assign res_index     = res_index_reg;
    assign res_timeout   = res_timeout_reg;
    assign res_trunc     = res_trunc_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_sme_driver.sv
// Self-checking bench for sme_driver: random records compared against a record-level model
// (truncated prefixes, SME response timing, timeout arithmetic).
module tb_sme_driver;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_kind = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic       res_trunc;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rec_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic       cap_wrong;

    always #5 clk = ~clk;

    sme_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .res_trunc(res_trunc), .busy(busy)
    );

    task automatic make_rec(input int len);
        rec_q.delete();
        for (int i = 0; i < len; i++) rec_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Model: the burst is the record truncated to the per-kind maximum.
    task automatic model_burst(input logic kind);
        int lim;
        lim = kind ? PAT_MAX : STR_MAX;
        exp_q.delete();
        for (int i = 0; i < rec_q.size() && i < lim; i++) exp_q.push_back(rec_q[i]);
    endtask

    function automatic logic burst_eq();
        if (cap_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_record(input logic kind);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < rec_q.size() && guard < 300) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_kind  = kind;
            in_data  = rec_q[i];
            in_last  = (i == rec_q.size() - 1);
            if (in_ready) i++;
            guard++;
        end
        n_tests++;
        if (i != rec_q.size()) begin
            n_fail++;
            $display("FAIL drive_accept: accepted %0d bytes, required %0d", i, rec_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Collects one framed burst; ends at the first negedge with framing low. Drops sme_valid there.
    task automatic capture(input logic kind);
        int guard;
        logic seen;
        logic fr;
        cap_q.delete();
        cap_wrong = 1'b0;
        seen = 1'b0;
        guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            guard++;
            fr = kind ? sme_ispattern : sme_isstring;
            if (kind ? sme_isstring : sme_ispattern) cap_wrong = 1'b1;
            if (fr) begin
                cap_q.push_back(sme_chardata);
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        sme_valid = 1'b0;
        if (!seen) cap_wrong = 1'b1;
    endtask

    task automatic sme_respond(input int d, input logic m, input logic [4:0] idx);
        repeat (d) @(negedge clk);
        sme_match = m;
        sme_match_index = idx;
        sme_valid = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < TIMEOUT + 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({in_ready, sme_isstring, sme_ispattern, sme_chardata, res_valid, res_match,
             res_index, res_timeout, res_trunc, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs ready=%b frame=%b%b busy=%b rv=%b, required all 0",
                     in_ready, sme_isstring, sme_ispattern, busy, res_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        rec_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        drive_record(1'b0);
        capture(1'b0);
        model_burst(1'b0);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL basic_string: got %0d bytes first=%h, required 4 bytes 41..44", cap_q.size(),
                     cap_q.size() > 0 ? cap_q[0] : 8'h00);
        end
        rec_q = '{8'h42, 8'h43};
        drive_record(1'b1);
        capture(1'b1);
        model_burst(1'b1);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL basic_pattern: got %0d bytes, required 2 bytes 42 43", cap_q.size());
        end
        sme_respond($urandom_range(0, 4), 1'b1, 5'd1);
        wait_result(cyc);
        n_tests++;
        if ({res_valid, res_match, res_index, res_timeout, res_trunc} !== {1'b1, 1'b1, 5'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got v=%b m=%b i=%0d t=%b tr=%b, required 1 1 1 0 0",
                     res_valid, res_match, res_index, res_timeout, res_trunc);
        end
        handshake();
    endtask

    task automatic test_hold();
        int cyc;
        logic stable;
        logic [4:0] idx0;
        rec_q = '{8'h5A, 8'h5A};
        drive_record(1'b1);
        capture(1'b1);
        sme_respond($urandom_range(0, 6), 1'b0, 5'($urandom_range(0, 31)));
        wait_result(cyc);
        n_tests++;
        if ({res_valid, res_match, res_timeout, res_trunc} !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_result: got v=%b m=%b t=%b tr=%b, required 1 0 0 0",
                     res_valid, res_match, res_timeout, res_trunc);
        end
        idx0 = res_index;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_match !== 1'b0 || res_index !== idx0 || res_timeout !== 1'b0) stable = 1'b0;
        end
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL hold_stable: got result changing while res_ready low, required stable");
        end
        handshake();
        n_tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_clear: got res_valid=%b in_ready=%b after handshake, required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_trunc();
        int cyc;
        make_rec(40);
        drive_record(1'b0);
        capture(1'b0);
        model_burst(1'b0);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL trunc_string: got %0d bytes, required %0d matching", cap_q.size(), exp_q.size());
        end
        make_rec(10);
        drive_record(1'b1);
        capture(1'b1);
        model_burst(1'b1);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL trunc_pattern: got %0d bytes, required %0d matching", cap_q.size(), exp_q.size());
        end
        sme_respond(2, 1'b1, 5'd7);
        wait_result(cyc);
        n_tests++;
        if ({res_valid, res_match, res_index, res_timeout, res_trunc} !== {1'b1, 1'b1, 5'd7, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL trunc_result: got v=%b m=%b i=%0d t=%b tr=%b, required 1 1 7 0 1",
                     res_valid, res_match, res_index, res_timeout, res_trunc);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int cyc;
        make_rec($urandom_range(1, PAT_MAX));
        drive_record(1'b1);
        capture(1'b1);
        wait_result(cyc);
        n_tests++;
        if (cyc != TIMEOUT || {res_valid, res_match, res_index, res_timeout, res_trunc} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_result: got %0d cycles v=%b m=%b i=%0d t=%b, required %0d cycles 1 0 0 1",
                     cyc, res_valid, res_match, res_index, res_timeout, TIMEOUT);
        end
        handshake();
        // Valid arriving on the last WAIT cycle beats the timeout
        make_rec(3);
        drive_record(1'b1);
        capture(1'b1);
        sme_respond(TIMEOUT - 1, 1'b1, 5'd9);
        wait_result(cyc);
        n_tests++;
        if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_coincide: got v=%b m=%b i=%0d t=%b, required 1 1 9 0",
                     res_valid, res_match, res_index, res_timeout);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int seen;
        int guard;
        make_rec(6);
        drive_record(1'b0);
        seen = 0;
        guard = 0;
        while (seen < 3 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (sme_isstring) seen++;
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (seen != 3 || {in_ready, sme_isstring, sme_ispattern, sme_chardata, res_valid, res_match,
                          res_index, res_timeout, res_trunc, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got seen=%0d isstring=%b busy=%b data=%h, required seen=3 all outputs 0",
                     seen, sme_isstring, busy, sme_chardata);
        end
        @(negedge clk);
        reset = 1'b1;
        rec_q = '{8'h41, 8'h42};
        drive_record(1'b0);
        capture(1'b0);
        model_burst(1'b0);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL reset_recover: got %0d bytes, required 2 bytes 41 42", cap_q.size());
        end
    endtask

    task automatic test_ignore();
        int cyc;
        logic any_res;
        sme_match = 1'b1;
        sme_match_index = 5'd31;
        sme_valid = 1'b1;
        make_rec(5);
        drive_record(1'b0);
        capture(1'b0);
        any_res = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) any_res = 1'b1;
        end
        n_tests++;
        if (any_res) begin
            n_fail++;
            $display("FAIL ignore_string: got res_valid/busy after string, required none");
        end
        sme_valid = 1'b1;
        make_rec(1);
        drive_record(1'b1);
        capture(1'b1);
        model_burst(1'b1);
        n_tests++;
        if (!burst_eq() || cap_wrong) begin
            n_fail++;
            $display("FAIL ignore_single: got %0d framed bytes, required 1", cap_q.size());
        end
        wait_result(cyc);
        n_tests++;
        if (cyc != TIMEOUT || {res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ignore_result: got %0d cycles m=%b i=%0d t=%b, required %0d cycles timeout result",
                     cyc, res_match, res_index, res_timeout, TIMEOUT);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int d;
        int len;
        logic kind;
        logic m;
        logic [4:0] idx;
        logic to;
        for (int it = 0; it < 10; it++) begin
            kind = 1'($urandom_range(0, 1));
            len  = kind ? $urandom_range(1, 12) : $urandom_range(1, 40);
            make_rec(len);
            drive_record(kind);
            capture(kind);
            model_burst(kind);
            n_tests++;
            if (!burst_eq() || cap_wrong) begin
                n_fail++;
                $display("FAIL b2b_burst[%0d]: kind=%0d len=%0d got %0d bytes, required %0d", it, kind, len,
                         cap_q.size(), exp_q.size());
            end
            if (!kind) begin
                n_tests++;
                if (in_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got in_ready=%b busy=%b, required 1 0", it, in_ready, busy);
                end
            end else begin
                d   = $urandom_range(0, TIMEOUT + 2);
                m   = 1'($urandom_range(0, 1));
                idx = 5'($urandom_range(0, 31));
                to  = (d >= TIMEOUT);
                sme_respond(d, m, idx);
                wait_result(cyc);
                n_tests++;
                if ({res_valid, res_match, res_index, res_timeout, res_trunc} !==
                    {1'b1, to ? 1'b0 : m, to ? 5'd0 : idx, to, len > PAT_MAX}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got v=%b m=%b i=%0d t=%b tr=%b, required 1 %b %0d %b %b", it,
                             res_valid, res_match, res_index, res_timeout, res_trunc,
                             to ? 1'b0 : m, to ? 5'd0 : idx, to, len > PAT_MAX);
                end
                handshake();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_trunc();
        test_timeout();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
